// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed common-anode 7-segment hex display driver
module seven_segment_scan #(
  parameter int NUM_SEGMENTS = 4,
  parameter int CLK_PER      = 10,
  parameter int REFR_RATE    = 1000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_SEGMENTS-1:0][3:0] encoded,
  input  logic [NUM_SEGMENTS-1:0]      digit_point,
  output logic [NUM_SEGMENTS-1:0]      anode,
  output logic [7:0]                   cathode
);

  localparam int DWELL_RAW = 1_000_000_000 / (CLK_PER * REFR_RATE);
  localparam int DWELL     = (DWELL_RAW < 1) ? 1 : DWELL_RAW;
  localparam int CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W     = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_SEGMENTS - 1);

  logic [CNT_W-1:0] dwell_cnt;
  logic [IDX_W-1:0] digit_idx;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt <= '0;
      digit_idx <= '0;
      anode     <= '1;
      cathode   <= 8'hFF;
    end else begin
      if (dwell_cnt == CNT_MAX) begin
        dwell_cnt <= '0;
        digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
      // Inputs are sampled live every cycle so datapath changes show within one clock.
      anode   <= ~(NUM_SEGMENTS'(1) << digit_idx);
      cathode <= {digit_point[digit_idx], seg_decode(encoded[digit_idx])};
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - directed self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

  logic             clk;
  logic             reset_n;
  logic [3:0][3:0]  encoded;
  logic [3:0]       digit_point;
  logic [3:0]       anode;
  logic [7:0]       cathode;

  int n_checks;
  int n_fail;

  logic [3:0] scan_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] scan_ca  [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_segment_scan #(
    .NUM_SEGMENTS(4),
    .CLK_PER(10),
    .REFR_RATE(10_000_000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .encoded(encoded),
    .digit_point(digit_point),
    .anode(anode),
    .cathode(cathode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves reset released on a negedge; the next posedge is the first post-reset edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    encoded     = {4'h3, 4'h2, 4'h1, 4'h0};
    digit_point = 4'hF;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (anode !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_anode: got %h expected %h", anode, 4'hF);
    end
    n_checks++;
    if (cathode !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_cathode: got %h expected %h", cathode, 8'hFF);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (anode !== 4'hE) begin
      n_fail++;
      $display("FAIL reset_release_anode: got %h expected %h", anode, 4'hE);
    end
    n_checks++;
    if (cathode !== 8'hC0) begin
      n_fail++;
      $display("FAIL reset_release_cathode: got %h expected %h", cathode, 8'hC0);
    end
  endtask

  task automatic test_scan();
    encoded     = {4'h3, 4'h2, 4'h1, 4'h0};
    digit_point = 4'hF;
    apply_reset();
    for (int k = 1; k <= 50; k++) begin
      int d;
      @(negedge clk);
      d = ((k - 1) / 10) % 4;
      n_checks++;
      if (anode !== scan_an[d] || cathode !== scan_ca[d]) begin
        n_fail++;
        $display("FAIL scan_edge%0d: got anode=%h cathode=%h expected anode=%h cathode=%h",
                 k, anode, cathode, scan_an[d], scan_ca[d]);
      end
    end
  endtask

  task automatic test_decode();
    digit_point = 4'hF;
    for (int v = 0; v < 16; v++) begin
      encoded = {4'h3, 4'h2, 4'h1, 4'(v)};
      apply_reset();
      @(negedge clk);
      n_checks++;
      if (anode !== 4'hE || cathode !== {1'b1, seg_tbl[v]}) begin
        n_fail++;
        $display("FAIL decode_%h: got anode=%h cathode=%h expected anode=%h cathode=%h",
                 v[3:0], anode, cathode, 4'hE, {1'b1, seg_tbl[v]});
      end
    end
  endtask

  task automatic test_dp();
    encoded     = {4'h3, 4'h2, 4'h1, 4'h0};
    digit_point = 4'b1110;
    apply_reset();
    for (int k = 1; k <= 40; k++) begin
      int   d;
      logic exp_dp;
      @(negedge clk);
      d      = ((k - 1) / 10) % 4;
      exp_dp = (d == 0) ? 1'b0 : 1'b1;
      n_checks++;
      if (anode !== scan_an[d] || cathode[7] !== exp_dp) begin
        n_fail++;
        $display("FAIL dp_edge%0d: got anode=%h dp=%b expected anode=%h dp=%b",
                 k, anode, cathode[7], scan_an[d], exp_dp);
      end
    end
    digit_point = 4'hF;
  endtask

  task automatic test_live_update();
    encoded     = {4'h3, 4'h2, 4'h1, 4'h5};
    digit_point = 4'hF;
    apply_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (anode !== 4'hE || cathode !== 8'h92) begin
      n_fail++;
      $display("FAIL live_before: got anode=%h cathode=%h expected anode=E cathode=92",
               anode, cathode);
    end
    encoded[0] = 4'hA;
    @(negedge clk);
    n_checks++;
    if (anode !== 4'hE || cathode !== 8'h88) begin
      n_fail++;
      $display("FAIL live_after: got anode=%h cathode=%h expected anode=E cathode=88",
               anode, cathode);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (anode !== 4'hE || cathode !== 8'h88) begin
      n_fail++;
      $display("FAIL live_dwell_end: got anode=%h cathode=%h expected anode=E cathode=88",
               anode, cathode);
    end
    @(negedge clk);
    n_checks++;
    if (anode !== 4'hD || cathode !== 8'hF9) begin
      n_fail++;
      $display("FAIL live_next_digit: got anode=%h cathode=%h expected anode=D cathode=F9",
               anode, cathode);
    end
  endtask

  task automatic test_async_reset();
    encoded     = {4'h3, 4'h2, 4'h1, 4'h0};
    digit_point = 4'hF;
    apply_reset();
    repeat (25) @(negedge clk);
    n_checks++;
    if (anode !== 4'hB || cathode !== 8'hA4) begin
      n_fail++;
      $display("FAIL async_pre: got anode=%h cathode=%h expected anode=B cathode=A4",
               anode, cathode);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (anode !== 4'hF || cathode !== 8'hFF) begin
      n_fail++;
      $display("FAIL async_blank: got anode=%h cathode=%h expected anode=F cathode=FF",
               anode, cathode);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (anode !== 4'hE || cathode !== 8'hC0) begin
      n_fail++;
      $display("FAIL async_restart: got anode=%h cathode=%h expected anode=E cathode=C0",
               anode, cathode);
    end
    repeat (9) @(negedge clk);
    n_checks++;
    if (anode !== 4'hE) begin
      n_fail++;
      $display("FAIL async_full_dwell: got anode=%h expected anode=E", anode);
    end
    @(negedge clk);
    n_checks++;
    if (anode !== 4'hD || cathode !== 8'hF9) begin
      n_fail++;
      $display("FAIL async_next_digit: got anode=%h cathode=%h expected anode=D cathode=F9",
               anode, cathode);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    encoded     = '0;
    digit_point = 4'hF;
    test_reset();
    test_scan();
    test_decode();
    test_dp();
    test_live_update();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
